// File: rtl/regfile_3bus.sv
// regfile_3bus: 32 x 32-bit RV32I integer register file with two combinational
// read ports (ALU operand buses A/B) and one write port (result bus).
// x0 is hardwired to zero. WrCount is a saturating count of committed writes.
// Optional build macro REGFILE_BYPASS_EN adds a write-through bypass so a read of
// the register being written returns WD in the same cycle.
module regfile_3bus #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   RA1,
  input  logic [AW-1:0]   RA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE,
  input  logic [AW-1:0]   WA,
  input  logic [XLEN-1:0] WD,
  output logic [15:0]     WrCount
);

  logic [XLEN-1:0] regs [NREGS];
  logic [15:0]     wr_count;
  logic            commit;

  // A write with WA == 0 targets x0 and is dropped entirely, counter included.
  assign commit = WE && (WA != '0);

  // Register array: async clear, single write per cycle. Entry 0 is cleared but
  // never written, and reads of address 0 are forced to zero anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[WA] <= WD;
    end
  end

  // Committed-write counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (commit && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  assign WrCount = wr_count;

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Bypass only for a live, non-x0 write; reset gating is applied below.
  always_comb begin
    byp1 = commit && (RA1 == WA);
    byp2 = commit && (RA2 == WA);
  end

  // Read ports with write-through: new data is visible in the write cycle.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (rst_n) begin
      if (RA1 != '0) RD1 = byp1 ? WD : regs[RA1];
      if (RA2 != '0) RD2 = byp2 ? WD : regs[RA2];
    end
  end
`else
  // Read ports: plain array lookup, old value seen during a same-cycle write.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (rst_n) begin
      if (RA1 != '0) RD1 = regs[RA1];
      if (RA2 != '0) RD2 = regs[RA2];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_3bus.sv
// Self-checking bench for regfile_3bus: table-driven vectors plus directed
// sequences for reset, reset-during-write and counter saturation.
module tb_regfile_3bus;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  RA1, RA2, WA;
  logic [31:0] RD1, RD2, WD;
  logic        WE;
  logic [15:0] WrCount;

  int errors = 0;
  int checks = 0;

  regfile_3bus dut (
    .clk(clk), .rst_n(rst_n),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE(WE), .WA(WA), .WD(WD), .WrCount(WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // expected values are sampled before the rising edge of the row's cycle
    vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd3,
                 BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 16'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h12345678, 32'h12345678, 16'd1};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'h12345678, 16'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        16'd1};
    vecs[4]  = '{1'b1, 5'd7,  32'h00000011, 5'd3,  5'd0,  32'h12345678, 32'h0,        16'd1};
    vecs[5]  = '{1'b1, 5'd7,  32'h00000022, 5'd3,  5'd7,
                 32'h12345678, BYP ? 32'h22 : 32'h11, 16'd2};
    vecs[6]  = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       16'd3};
    vecs[7]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd7,
                 BYP ? 32'hCAFEF00D : 32'h0, 32'h22, 16'd3};
    vecs[8]  = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd3,  32'hCAFEF00D, 32'h12345678, 16'd4};
    vecs[9]  = '{1'b1, 5'd3,  32'h1,        5'd3,  5'd31,
                 BYP ? 32'h1 : 32'h12345678, 32'hCAFEF00D, 16'd4};
    vecs[10] = '{1'b1, 5'd3,  32'h2,        5'd3,  5'd3,
                 BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 16'd5};
    vecs[11] = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd1,  32'h2,        32'h0,        16'd6};

    rst_n = 1'b0;
    WE = 1'b0; WA = '0; WD = '0; RA1 = 5'd3; RA2 = 5'd7;
    #1;
    chk("reset_rd1", RD1, 32'h0);
    chk("reset_rd2", RD2, 32'h0);
    chk("reset_cnt", {16'h0, WrCount}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      WE = vecs[i].we; WA = vecs[i].wa; WD = vecs[i].wd;
      RA1 = vecs[i].ra1; RA2 = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), RD1, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), RD2, vecs[i].e2);
      chk($sformatf("vec%0d_cnt", i), {16'h0, WrCount}, {16'h0, vecs[i].ecnt});
    end

    // async reset after writing x5
    @(negedge clk);
    WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF;
    @(negedge clk);
    WE = 1'b0; RA1 = 5'd5; RA2 = 5'd5;
    #1;
    chk("x5_written", RD1, 32'hDEADBEEF);
    chk("cnt_before_rst", {16'h0, WrCount}, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", RD1, 32'h0);
    chk("async_rst_cnt", {16'h0, WrCount}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      RA1 = 5'(a); RA2 = 5'(31 - a);
      #1;
      chk($sformatf("scan_rd1_x%0d", a), RD1, 32'h0);
      chk($sformatf("scan_rd2_x%0d", 31 - a), RD2, 32'h0);
    end

    // reset asserted across a write edge
    @(negedge clk);
    WE = 1'b1; WA = 5'd9; WD = 32'hA5A5A5A5; RA1 = 5'd9; RA2 = 5'd9;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_blocks_bypass", RD1, 32'h0);
    @(posedge clk);
    #2;
    WE = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_write_x9", RD2, 32'h0);
    chk("rst_mid_write_cnt", {16'h0, WrCount}, 32'h0);

    // saturation: 65540 writes to x1, WD = index
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      WE = 1'b1; WA = 5'd1; WD = 32'(i);
      if (i == 2 || i == 65534) begin
        #1;
        chk($sformatf("sat_cnt_at_%0d", i), {16'h0, WrCount}, 32'(i));
      end
    end
    @(negedge clk);
    WE = 1'b0; RA1 = 5'd1; RA2 = 5'd0;
    #1;
    chk("sat_x1_last", RD1, 32'h00010003);
    chk("sat_cnt_hold", {16'h0, WrCount}, 32'h0000FFFF);
    chk("sat_x0_zero", RD2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
